ram_latency_responder: RTL and testbench
========================================

// Module: ram_latency_responder
// PURPOSE
//   RAM-side responder for cpu_ram_if: the endpoint the memory controller's ram* bus talks to.
//   Word-addressed storage with a fixed, parameterised access latency. Reports FREE/BUSY/ACCESS/ERROR on ramstate.
//   Used as the synthesizable memory under the single-cycle/pipeline top and as the bench memory model.
// PARAMETERS
//   LAT    2      BUSY cycles before ACCESS for each request (0..15); 0 = ACCESS in first request cycle
//   DEPTH  16384  storage size in 32-bit words (power of two); byte span = 4*DEPTH
// PORTS
//   CLK       in   1   clock, rising edge
//   nRST      in   1   reset: asynchronous, active-low
//   memaddr   in   32  byte address of request; bits [1:0] ignored
//   memstore  in   32  write data
//   memREN    in   1   read request, level, held until ACCESS seen
//   memWEN    in   1   write request, level, held until ACCESS seen
//   ramload   out  32  read data, valid only while ramstate==ACCESS for a read
//   ramstate  out  2   ramstate_t: FREE, BUSY, ACCESS, ERROR
// BEHAVIOUR
//   - Reset (nRST=0, async): state IDLE, cnt=0, latched addr/type=0; ramstate=FREE, ramload=0.
//     Storage contents are NOT reset.
//   - States: IDLE, WAIT, DONE.
//     IDLE: no request -> ramstate=FREE.
//       Valid request -> latch {addr[31:2], type}, cnt=0.
//       LAT==0 -> ACCESS combinationally this cycle, then go DONE; else ramstate=BUSY and go WAIT.
//     WAIT: ramstate=BUSY; cnt increments each cycle.
//       When cnt==LAT-1, ramstate=ACCESS for that cycle and go DONE.
//     DONE: one cycle. If the requester still holds the identical request, ramstate=BUSY and go WAIT with cnt=0.
//       This makes back-to-back same-address accesses each pay LAT; otherwise go IDLE (FREE).
//   - Latency: a request held from cycle t gets exactly one ACCESS cycle, at t+LAT.
//   - Read: ramload = mem[addr[31:2]] during ACCESS; ramload=0 in all other cycles.
//   - Write: mem[addr[31:2]] <= memstore on the rising edge closing the ACCESS cycle.
//     Only one word is written per ACCESS.
//   - Request change mid-WAIT: a different addr, a type flip, or a dropped request cancels the access; no write occurs.
//     The new request is latched and cnt restarts at 0. A dropped request -> IDLE.
//   - memREN && memWEN together -> ramstate=ERROR, no access, state IDLE; held while both remain high.
//   - addr[31:2] >= DEPTH -> ramstate=ERROR for that request, no access, state stays IDLE.
//     Addresses never wrap or alias.
//   - Misaligned addr (bits[1:0]!=0) is not an error; the low bits are dropped.
//   - nRST asserted mid-WAIT aborts the access immediately: a pending write is discarded, outputs go to reset values.
//   - cnt is width 4; LAT>15 is illegal and rejected by an elaboration-time assertion.
// STRUCTURE
//   - cpu_types_pkg: word_t (32b), ramstate_t {FREE,BUSY,ACCESS,ERROR}.
//     Add the local FSM enum ramresp_state_t {IDLE,WAIT,DONE} there.
//   - Sub-module ram_word_array #(DEPTH): 1 synchronous write port, 1 combinational read port.
//     Kept separate so an FPGA block-RAM version can be swapped in.
//   - Top: FSM + latency counter + request latch + compare logic, about 150-250 lines.
// TESTING
//   1 LAT=2: write 0xDEADBEEF @0x40, held -> BUSY,BUSY,ACCESS; then read @0x40 -> ACCESS cycle ramload=0xDEADBEEF.
//   2 LAT=0: read @0x0 after write 0x12345678 -> ACCESS same cycle as request, ramload=0x12345678; FREE once dropped.
//   3 LAT=3 write @0x80 of 0xAAAA5555, addr switched to 0x84 in cycle 2 -> restart.
//     ACCESS at cycle 2+3 for 0x84; a read of 0x80 then returns its prior value.
//   4 memREN=memWEN=1 @0x10 -> ERROR every cycle held, no ACCESS, mem[0x10] unchanged.
//     Read @4*DEPTH -> ERROR.
//   5 nRST pulsed low during BUSY of write 0xCAFEF00D @0x20 -> ramstate=FREE, ramload=0 immediately.
//     Later read @0x20 returns the old value.
//   6 LAT=2 read @0x8 held for 7 cycles -> BUSY,BUSY,ACCESS,BUSY,BUSY,ACCESS,BUSY, each ACCESS with same data.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU/RAM bus types and the responder's local FSM encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Status the RAM side reports back to the memory controller.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    // Responder sequencing states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } ramresp_state_t;

    localparam int CNT_W   = 4;
    localparam int LAT_MAX = (1 << CNT_W) - 1;

endpackage

// File: rtl/cpu_ram_if.sv
// Memory controller <-> RAM bus. master = controller side, slave = RAM side.
interface cpu_ram_if;
    import cpu_types_pkg::*;

    word_t     memaddr;
    word_t     memstore;
    logic      memREN;
    logic      memWEN;
    word_t     ramload;
    ramstate_t ramstate;

    modport master (
        output memaddr, memstore, memREN, memWEN,
        input  ramload, ramstate
    );

    modport slave (
        input  memaddr, memstore, memREN, memWEN,
        output ramload, ramstate
    );

endinterface

// File: rtl/ram_word_array.sv
// Word storage: one synchronous write port, one combinational read port.
// Isolated so a vendor block-RAM wrapper can replace it without touching the FSM.
module ram_word_array
    import cpu_types_pkg::*;
#(
    parameter int DEPTH = 16384
) (
    input  logic                     clk,
    input  logic                     wen,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  word_t                    wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output word_t                    rdata
);

    word_t mem [DEPTH];

    // Contents are intentionally not reset.
    always_ff @(posedge clk) begin
        if (wen) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ram_latency_responder.sv
// RAM-side responder: fixed-latency word memory behind cpu_ram_if.
// Each request pays LAT BUSY cycles, then exactly one ACCESS cycle.
module ram_latency_responder
    import cpu_types_pkg::*;
#(
    parameter int LAT   = 2,
    parameter int DEPTH = 16384
) (
    input  logic      CLK,
    input  logic      nRST,
    cpu_ram_if.slave  ram
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] LAT_LAST = (LAT == 0) ? '0 : CNT_W'(LAT - 1);

    if (LAT < 0 || LAT > LAT_MAX) begin : g_bad_lat
        $error("ram_latency_responder: LAT must be within 0..15");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ram_latency_responder: DEPTH must be a power of two >= 2");
    end

    ramresp_state_t   state, next_state;
    logic [CNT_W-1:0] cnt, next_cnt;
    logic [29:0]      lat_addr, next_addr;
    logic             lat_wr, next_wr;

    ramstate_t        rs;
    logic             acc;

    // Request decode. The byte offset bits are simply dropped.
    word_t       word_idx;
    logic [29:0] req_addr;
    logic        oob, any_req, both, req_err, req_ok, req_wr, same;
    logic        unused_low;

    assign req_addr   = ram.memaddr[31:2];
    assign word_idx   = {2'b00, req_addr};
    assign oob        = word_idx >= 32'(DEPTH);
    assign any_req    = ram.memREN | ram.memWEN;
    assign both       = ram.memREN & ram.memWEN;
    assign req_err    = both | (any_req & oob);
    assign req_ok     = any_req & ~both & ~oob;
    assign req_wr     = ram.memWEN;
    assign same       = (req_addr == lat_addr) && (req_wr == lat_wr);
    assign unused_low = &{1'b0, ram.memaddr[1:0]};

    // State, latency counter and request latch.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            cnt      <= '0;
            lat_addr <= '0;
            lat_wr   <= 1'b0;
        end else begin
            state    <= next_state;
            cnt      <= next_cnt;
            lat_addr <= next_addr;
            lat_wr   <= next_wr;
        end
    end

    // Next-state and bus status. ACCESS only fires when the live request
    // matches the latched one, so the live address/type drive the array.
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        next_addr  = lat_addr;
        next_wr    = lat_wr;
        rs         = FREE;
        acc        = 1'b0;

        if (req_err) begin
            rs         = ERROR;
            next_state = IDLE;
            next_cnt   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_ok) begin
                        next_addr = req_addr;
                        next_wr   = req_wr;
                        next_cnt  = '0;
                        if (LAT == 0) begin
                            rs         = ACCESS;
                            acc        = 1'b1;
                            next_state = DONE;
                        end else begin
                            rs         = BUSY;
                            next_state = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (!req_ok) begin
                        next_state = IDLE;
                        next_cnt   = '0;
                    end else if (!same) begin
                        // Request changed: abandon and restart the count.
                        rs        = BUSY;
                        next_addr = req_addr;
                        next_wr   = req_wr;
                        next_cnt  = '0;
                    end else if (cnt == LAT_LAST) begin
                        rs         = ACCESS;
                        acc        = 1'b1;
                        next_state = DONE;
                    end else begin
                        rs       = BUSY;
                        next_cnt = cnt + 1'b1;
                    end
                end
                DONE: begin
                    // A still-held identical request is a fresh access and pays LAT again.
                    if (req_ok && same) begin
                        if (LAT == 0) begin
                            rs  = ACCESS;
                            acc = 1'b1;
                        end else begin
                            rs         = BUSY;
                            next_state = WAIT;
                            next_cnt   = '0;
                        end
                    end else begin
                        next_state = IDLE;
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    logic  acc_go, mem_wen;
    word_t rdata;

    assign acc_go       = nRST & acc;
    assign mem_wen      = acc_go & req_wr;
    assign ram.ramstate = nRST ? rs : FREE;
    assign ram.ramload  = (acc_go & ~req_wr) ? rdata : '0;

    ram_word_array #(.DEPTH(DEPTH)) u_array (
        .clk   (CLK),
        .wen   (mem_wen),
        .waddr (ram.memaddr[AW+1:2]),
        .wdata (ram.memstore),
        .raddr (ram.memaddr[AW+1:2]),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_ram_latency_responder.sv
// Bench for ram_latency_responder: three instances (LAT=2, 0, 3), cycle-by-cycle
// expectations queued at drive time and compared on the falling edge.
module tb_ram_latency_responder;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    cpu_ram_if b0 ();
    cpu_ram_if b1 ();
    cpu_ram_if b2 ();

    ram_latency_responder #(.LAT(2), .DEPTH(16384)) dut0 (.CLK(CLK), .nRST(nRST), .ram(b0));
    ram_latency_responder #(.LAT(0), .DEPTH(256))   dut1 (.CLK(CLK), .nRST(nRST), .ram(b1));
    ram_latency_responder #(.LAT(3), .DEPTH(256))   dut2 (.CLK(CLK), .nRST(nRST), .ram(b2));

    typedef struct {
        int        dut;
        string     tag;
        ramstate_t st;
        word_t     ld;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input int d, input ramstate_t st, input word_t ld, input string tag);
        exp_t e;
        e.dut = d;
        e.tag = tag;
        e.st  = st;
        e.ld  = ld;
        exp_q.push_back(e);
    endtask

    task automatic drive(input int d, input logic ren, input logic wen, input word_t a, input word_t wd);
        case (d)
            0: begin b0.memREN = ren; b0.memWEN = wen; b0.memaddr = a; b0.memstore = wd; end
            1: begin b1.memREN = ren; b1.memWEN = wen; b1.memaddr = a; b1.memstore = wd; end
            default: begin b2.memREN = ren; b2.memWEN = wen; b2.memaddr = a; b2.memstore = wd; end
        endcase
    endtask

    // One clock: drive just after the rising edge, queue what that cycle must show.
    task automatic cyc(input int d, input logic ren, input logic wen, input word_t a, input word_t wd,
                       input ramstate_t st, input word_t ld, input string tag);
        @(posedge CLK);
        #1;
        drive(d, ren, wen, a, wd);
        expect_out(d, st, ld, tag);
    endtask

    // Held request: lat BUSY cycles, one ACCESS, then a dropped cycle showing FREE.
    task automatic op(input int d, input logic ren, input logic wen, input word_t a, input word_t wd,
                      input word_t rd, input int lat, input string tag);
        for (int i = 0; i < lat; i++) cyc(d, ren, wen, a, wd, BUSY, 32'h0, tag);
        cyc(d, ren, wen, a, wd, ACCESS, ren ? rd : 32'h0, {tag, "_acc"});
        cyc(d, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, {tag, "_idle"});
    endtask

    // Scoreboard: every queued expectation is compared on the falling edge.
    exp_t      cur;
    ramstate_t gs;
    word_t     gl;
    always @(negedge CLK) begin
        while (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            case (cur.dut)
                0:       begin gs = b0.ramstate; gl = b0.ramload; end
                1:       begin gs = b1.ramstate; gl = b1.ramload; end
                default: begin gs = b2.ramstate; gl = b2.ramload; end
            endcase
            chk({cur.tag, "_st"}, {30'h0, gs}, {30'h0, cur.st});
            chk({cur.tag, "_ld"}, gl, cur.ld);
        end
    end

    initial begin
        nRST = 1'b0;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
        expect_out(0, FREE, 32'h0, "rst0");
        expect_out(1, FREE, 32'h0, "rst1");
        expect_out(2, FREE, 32'h0, "rst2");
        @(negedge CLK);
        #1 nRST = 1'b1;

        // LAT=2: write then read back, plus a misaligned read of the same word.
        op(0, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, 32'h0, 2, "t1_w");
        op(0, 1'b1, 1'b0, 32'h40, 32'h0, 32'hDEADBEEF, 2, "t1_r");
        op(0, 1'b1, 1'b0, 32'h43, 32'h0, 32'hDEADBEEF, 2, "t1_mis");

        // LAT=0: ACCESS in the request cycle.
        op(1, 1'b0, 1'b1, 32'h0, 32'h12345678, 32'h0, 0, "t2_w");
        op(1, 1'b1, 1'b0, 32'h0, 32'h0, 32'h12345678, 0, "t2_r");

        // LAT=3: address switched mid-wait restarts the count; old word untouched.
        op(2, 1'b0, 1'b1, 32'h80, 32'h01010101, 32'h0, 3, "t3_pre");
        cyc(2, 1'b0, 1'b1, 32'h80, 32'hAAAA5555, BUSY, 32'h0, "t3_c0");
        cyc(2, 1'b0, 1'b1, 32'h80, 32'hAAAA5555, BUSY, 32'h0, "t3_c1");
        cyc(2, 1'b0, 1'b1, 32'h84, 32'hAAAA5555, BUSY, 32'h0, "t3_c2");
        cyc(2, 1'b0, 1'b1, 32'h84, 32'hAAAA5555, BUSY, 32'h0, "t3_c3");
        cyc(2, 1'b0, 1'b1, 32'h84, 32'hAAAA5555, BUSY, 32'h0, "t3_c4");
        cyc(2, 1'b0, 1'b1, 32'h84, 32'hAAAA5555, ACCESS, 32'h0, "t3_c5");
        cyc(2, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "t3_idle");
        op(2, 1'b1, 1'b0, 32'h80, 32'h0, 32'h01010101, 3, "t3_r80");
        op(2, 1'b1, 1'b0, 32'h84, 32'h0, 32'hAAAA5555, 3, "t3_r84");

        // Both strobes high -> ERROR while held, no write.
        op(0, 1'b0, 1'b1, 32'h10, 32'h11110010, 32'h0, 2, "t4_pre");
        for (int i = 0; i < 3; i++) cyc(0, 1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, ERROR, 32'h0, "t4_both");
        cyc(0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "t4_both_idle");
        op(0, 1'b1, 1'b0, 32'h10, 32'h0, 32'h11110010, 2, "t4_r10");

        // Out-of-range: ERROR, and a write there must not alias onto word 0.
        op(0, 1'b0, 1'b1, 32'h0, 32'h00C0FFEE, 32'h0, 2, "t4_w0");
        cyc(0, 1'b1, 1'b0, 32'h10000, 32'h0, ERROR, 32'h0, "t4_oob_r");
        cyc(0, 1'b0, 1'b1, 32'h10000, 32'h77777777, ERROR, 32'h0, "t4_oob_w");
        cyc(0, 1'b0, 1'b1, 32'h10000, 32'h77777777, ERROR, 32'h0, "t4_oob_w2");
        cyc(0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "t4_oob_idle");
        op(0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h00C0FFEE, 2, "t4_r0");

        // Reset mid-wait discards the pending write.
        op(0, 1'b0, 1'b1, 32'h20, 32'h0BADBEEF, 32'h0, 2, "t5_pre");
        cyc(0, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, BUSY, 32'h0, "t5_busy");
        @(posedge CLK);
        #1 nRST = 1'b0;
        expect_out(0, FREE, 32'h0, "t5_rst");
        @(negedge CLK);
        #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        nRST = 1'b1;
        cyc(0, 1'b0, 1'b0, 32'h0, 32'h0, FREE, 32'h0, "t5_after");
        op(0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h0BADBEEF, 2, "t5_r");

        // Held identical read pays LAT again after each ACCESS.
        op(0, 1'b0, 1'b1, 32'h8, 32'h88888888, 32'h0, 2, "t6_pre");
        cyc(0, 1'b1, 1'b0, 32'h8, 32'h0, BUSY,   32'h0,        "t6_c0");
        cyc(0, 1'b1, 1'b0, 32'h8, 32'h0, BUSY,   32'h0,        "t6_c1");
        cyc(0, 1'b1, 1'b0, 32'h8, 32'h0, ACCESS, 32'h88888888, "t6_c2");
        cyc(0, 1'b1, 1'b0, 32'h8, 32'h0, BUSY,   32'h0,        "t6_c3");
        cyc(0, 1'b1, 1'b0, 32'h8, 32'h0, BUSY,   32'h0,        "t6_c4");
        cyc(0, 1'b1, 1'b0, 32'h8, 32'h0, ACCESS, 32'h88888888, "t6_c5");
        cyc(0, 1'b1, 1'b0, 32'h8, 32'h0, BUSY,   32'h0,        "t6_c6");
        cyc(0, 1'b0, 1'b0, 32'h0, 32'h0, FREE,   32'h0,        "t6_idle");

        @(negedge CLK);
        #1;
        chk("q_drained", 32'(exp_q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
